// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state encoding and default sizing for the FIFO-fed UART transmitter
package fifo_uart_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_STOP = 3'd5;
  typedef enum logic [2:0] {
    IDLE = S_IDLE, FETCH = S_FETCH, LATCH = S_LATCH,
    START = S_START, DATA = S_DATA, STOP = S_STOP
  } state_t;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count of each bit
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(CLKS_PER_BIT - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead-less FIFO read port and sends them as 8N1-style frames
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(DATA_W + 1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic tx_q, tx_d, tick, clr, last;
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst(rst), .clr(clr), .tick(tick)
  );
  always_comb begin
    clr = state_q inside {IDLE, FETCH, LATCH};
    last = bit_q == BW'(DATA_W - 1);
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = FETCH;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && last) state_d = STOP;
      STOP:    if (tick) state_d = fifo_empty ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
    shift_d = state_q == LATCH ? fifo_data : (state_q == DATA && tick) ? shift_q >> 1 : shift_q;
    bit_d = state_q == LATCH ? '0 : (state_q == DATA && tick) ? bit_q + 1'b1 : bit_q;
    // tx is registered from the next state so the line changes exactly at state boundaries
    tx_d = state_d == DATA ? shift_d[0] : state_d != START;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
    end
  assign fifo_rd_en = state_q == FETCH;
  assign busy = state_q != IDLE;
  assign done = state_q == STOP && tick;
  assign tx = tx_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives a behavioural FIFO into the transmitter and decodes tx at bit mid-points
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int DW = 8;
  localparam int FRAME = (DW + 2) * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_empty, full;
  logic [7:0] fifo_data = 8'h00;
  logic fifo_rd_en, tx, busy, done;
  logic [7:0] mem [16];
  int wr_cnt = 0, rd_cnt = 0, cyc = 0, rd_pulses = 0, done_cnt = 0;
  int busy_cyc = 0, rd_cyc = 0, underflow = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .done(done)
  );
  assign fifo_empty = wr_cnt == rd_cnt;
  assign full = (wr_cnt - rd_cnt) == 16;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (fifo_rd_en) begin
      if (fifo_empty) underflow <= underflow + 1;
      else begin
        fifo_data <= mem[rd_cnt[3:0]];
        rd_cnt <= rd_cnt + 1;
      end
      rd_pulses <= rd_pulses + 1;
      rd_cyc <= cyc;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d expected finish earlier", cyc);
    $fatal(1);
  end
  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction
  task automatic push(input logic [7:0] b);
    mem[wr_cnt[3:0]] = b;
    wr_cnt++;
  endtask
  task automatic recv_frame(output logic [9:0] bits, output int t0, output bit ok);
    int n;
    n = 0;
    ok = 0;
    bits = '1;
    t0 = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) return;
    ok = 1;
    t0 = cyc;
    repeat (CPB / 2) @(negedge clk);
    bits[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) @(negedge clk);
      bits[i] = tx;
    end
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout busy=%b expected 0", busy); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask
  task automatic test_single();
    logic [9:0] bits;
    int t0, r0, d0, b0;
    bit ok;
    r0 = rd_pulses; d0 = done_cnt; b0 = busy_cyc;
    push(8'hA5);
    recv_frame(bits, t0, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL single_start got=none exp=start bit"); end
    if (bits !== frame(8'hA5)) begin errors++; $display("FAIL single_bits got=%b exp=%b", bits, frame(8'hA5)); end
    if (t0 - rd_cyc !== 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", t0 - rd_cyc); end
    wait_idle();
    checks += 3;
    if (rd_pulses - r0 !== 1) begin errors++; $display("FAIL single_pops got=%0d exp=1", rd_pulses - r0); end
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done got=%0d exp=1", done_cnt - d0); end
    if (busy_cyc - b0 !== FRAME + 2) begin errors++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cyc - b0, FRAME + 2); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] q [$];
    logic [7:0] b;
    logic [9:0] bits;
    int t0, tp, r0;
    bit ok;
    q = '{8'h00, 8'hFF, 8'h3C};
    r0 = rd_pulses;
    tp = 0;
    foreach (q[i]) push(q[i]);
    for (int i = 0; i < 3; i++) begin
      b = q.pop_front();
      recv_frame(bits, t0, ok);
      checks++;
      if (!ok || bits !== frame(b)) begin errors++; $display("FAIL b2b_frame%0d got=%b exp=%b", i, bits, frame(b)); end
      if (i > 0) begin
        checks++;
        if (t0 - tp !== FRAME + 2) begin errors++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, t0 - tp, FRAME + 2); end
      end
      tp = t0;
    end
    wait_idle();
    checks += 3;
    if (rd_pulses - r0 !== 3) begin errors++; $display("FAIL b2b_pops got=%0d exp=3", rd_pulses - r0); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", fifo_empty); end
    if (underflow !== 0) begin errors++; $display("FAIL b2b_underflow got=%0d exp=0", underflow); end
  endtask
  task automatic test_empty();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if ({fifo_rd_en, tx, busy} !== 3'b010) begin
        errors++;
        $display("FAIL empty_idle cyc=%0d got rd_en/tx/busy=%b exp=010", i, {fifo_rd_en, tx, busy});
      end
    end
  endtask
  task automatic test_reset_mid();
    int n, r0, lows;
    n = 0;
    push(8'h81);
    @(negedge clk);
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got=%b exp=0", tx); end
    rst = 1'b1;
    #1;
    checks += 3;
    if (tx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx got=%b exp=1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_en got=%b exp=0", fifo_rd_en); end
    @(negedge clk);
    rst = 1'b0;
    r0 = rd_pulses;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks += 2;
    if (rd_pulses !== r0) begin errors++; $display("FAIL mid_reread got=%0d exp=%0d", rd_pulses, r0); end
    if (lows !== 0) begin errors++; $display("FAIL mid_noframe got=%0d low cycles exp=0", lows); end
  endtask
  task automatic test_drain();
    logic [9:0] bits;
    int t0, r0, n;
    bit ok;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    @(negedge clk);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL drain_full got=%b exp=1", full); end
    r0 = rd_pulses;
    n = 0;
    rst = 1'b0;
    while (rd_pulses == r0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL drain_full_after_pop got=%b exp=0", full); end
    for (int i = 0; i < 16; i++) begin
      recv_frame(bits, t0, ok);
      checks++;
      if (!ok || bits !== frame(8'(i))) begin errors++; $display("FAIL drain_frame%0d got=%b exp=%b", i, bits, frame(8'(i))); end
    end
    checks += 2;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
    if (rd_pulses - r0 !== 16) begin errors++; $display("FAIL drain_pops got=%0d exp=16", rd_pulses - r0); end
    wait_idle();
  endtask
  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] b;
    logic [9:0] bits;
    int t0, cnt;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      cnt = $urandom_range(1, 5);
      for (int i = 0; i < cnt; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        push(b);
      end
      while (q.size() > 0) begin
        b = q.pop_front();
        recv_frame(bits, t0, ok);
        checks++;
        if (!ok || bits !== frame(b)) begin errors++; $display("FAIL random_r%0d got=%b exp=%b", r, bits, frame(b)); end
      end
      wait_idle();
    end
    checks++;
    if (underflow !== 0) begin errors++; $display("FAIL random_underflow got=%0d exp=0", underflow); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_reset_mid();
    test_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
